// File: rtl/exception_cp0_sequencer.sv
// rtl/exception_cp0_sequencer.sv - sequences CP0 reads/read-modify-writes for exception entry and ERET
// Walks Status/Cause/EPC/BadVAddr/EBase (or Status/EPC|ErrorEPC) one access per cycle, then pulses a redirect.
module exception_cp0_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_in_ds,
    input  logic        exc_has_badvaddr,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret_valid,
    output logic        req_ready,
    output logic        cp0_writeEn,
    output logic [4:0]  cp0_addr,
    output logic [2:0]  cp0_sel,
    output logic [31:0] cp0_writeData,
    input  logic [31:0] cp0_readData,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [3:0] {
        IDLE, E_STATUS, E_CAUSE, E_EPC, E_BADV, E_EBASE, R_STATUS, R_READ, REDIRECT
    } state_t;

    localparam logic [4:0]  REG_BADV     = 5'd8;
    localparam logic [4:0]  REG_STATUS   = 5'd12;
    localparam logic [4:0]  REG_CAUSE    = 5'd13;
    localparam logic [4:0]  REG_EPC      = 5'd14;
    localparam logic [4:0]  REG_EBASE    = 5'd15;
    localparam logic [4:0]  REG_ERROREPC = 5'd30;
    localparam logic [31:0] BEV_VECTOR   = 32'hBFC0_0380;

    state_t      state_q, state_d;
    logic [4:0]  code_q;
    logic [31:0] pc_q;
    logic        in_ds_q;
    logic        has_bv_q;
    logic [31:0] bv_q;
    logic        old_exl_q;
    logic        old_bev_q;
    logic        erl_q, erl_d;
    logic        we_q;
    logic [4:0]  addr_q;
    logic [2:0]  sel_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;
    logic        accept;

    // Port controls for the state about to be entered; R_READ needs the ERL seen in R_STATUS.
    function automatic logic [8:0] port_decode(input state_t s, input logic erl);
        logic [8:0] r;
        r = 9'd0;
        case (s)
            E_STATUS: r = {1'b1, REG_STATUS, 3'd0};
            E_CAUSE:  r = {1'b1, REG_CAUSE,  3'd0};
            E_EPC:    r = {1'b1, REG_EPC,    3'd0};
            E_BADV:   r = {1'b1, REG_BADV,   3'd0};
            E_EBASE:  r = {1'b0, REG_EBASE,  3'd1};
            R_STATUS: r = {1'b1, REG_STATUS, 3'd0};
            R_READ:   r = {1'b0, (erl ? REG_ERROREPC : REG_EPC), 3'd0};
            default:  r = 9'd0;
        endcase
        return r;
    endfunction

    assign accept = (state_q == IDLE) && (exc_valid || eret_valid);
    assign erl_d  = (state_q == R_STATUS) ? cp0_readData[2] : erl_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (exc_valid)       state_d = E_STATUS;
                else if (eret_valid) state_d = R_STATUS;
            end
            E_STATUS: state_d = E_CAUSE;
            E_CAUSE: begin
                if (!old_exl_q)    state_d = E_EPC;
                else if (has_bv_q) state_d = E_BADV;
                else               state_d = E_EBASE;
            end
            E_EPC:    state_d = has_bv_q ? E_BADV : E_EBASE;
            E_BADV:   state_d = E_EBASE;
            E_EBASE:  state_d = REDIRECT;
            R_STATUS: state_d = R_READ;
            R_READ:   state_d = REDIRECT;
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Write data is the read-modify-write of the register addressed this cycle.
    always_comb begin
        cp0_writeData = 32'd0;
        case (state_q)
            E_STATUS: cp0_writeData = cp0_readData | 32'h0000_0002;
            E_CAUSE: begin
                cp0_writeData      = cp0_readData;
                cp0_writeData[6:2] = code_q;
                if (!old_exl_q) cp0_writeData[31] = in_ds_q;
            end
            E_EPC:    cp0_writeData = in_ds_q ? (pc_q - 32'd4) : pc_q;
            E_BADV:   cp0_writeData = bv_q;
            R_STATUS: cp0_writeData = cp0_readData[2] ? (cp0_readData & ~32'h0000_0004)
                                                      : (cp0_readData & ~32'h0000_0002);
            default:  cp0_writeData = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            code_q           <= 5'd0;
            pc_q             <= 32'd0;
            in_ds_q          <= 1'b0;
            has_bv_q         <= 1'b0;
            bv_q             <= 32'd0;
            old_exl_q        <= 1'b0;
            old_bev_q        <= 1'b0;
            erl_q            <= 1'b0;
            we_q             <= 1'b0;
            addr_q           <= 5'd0;
            sel_q            <= 3'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else begin
            state_q                 <= state_d;
            {we_q, addr_q, sel_q}   <= port_decode(state_d, erl_d);
            redirect_valid_q        <= (state_d == REDIRECT);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        code_q   <= exc_code;
                        pc_q     <= exc_pc;
                        in_ds_q  <= exc_in_ds;
                        has_bv_q <= exc_has_badvaddr;
                        bv_q     <= exc_badvaddr;
                        erl_q    <= 1'b0;
                    end
                end
                E_STATUS: begin
                    old_exl_q <= cp0_readData[1];
                    old_bev_q <= cp0_readData[22];
                end
                E_EBASE:  redirect_pc_q <= old_bev_q ? BEV_VECTOR
                                                     : {cp0_readData[31:12], 12'h180};
                R_STATUS: erl_q <= cp0_readData[2];
                R_READ:   redirect_pc_q <= cp0_readData;
                default: ;
            endcase
        end
    end

    assign req_ready      = (state_q == IDLE) && rst;
    assign cp0_writeEn    = we_q;
    assign cp0_addr       = addr_q;
    assign cp0_sel        = sel_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: doc/exception_cp0_sequencer.md
# exception_cp0_sequencer

Master side of the CP0 exception write port: converts a committed exception or ERET into the ordered sequence of CP0 register reads and read-modify-writes (Status, Cause, EPC, BadVAddr, EBase/ErrorEPC) through a single CP0 access port. It then emits a one-cycle redirect with the handler vector or return PC. It sits between the commit stage and the CP0 exception port, one access per cycle, with a combinational read path.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- exc_valid  in  1  commit requests exception entry.
- exc_code  in  5  ExcCode for Cause[6:2].
- exc_pc  in  32  PC of faulting instruction.
- exc_in_ds  in  1  faulting instruction is in a branch delay slot.
- exc_has_badvaddr  in  1  BadVAddr must be written.
- exc_badvaddr  in  32  faulting address.
- eret_valid  in  1  commit requests ERET.
- req_ready  out  1  high only in IDLE; a request is accepted on a rising edge where (exc_valid|eret_valid) & req_ready.
- cp0_writeEn  out  1  CP0 write strobe.
- cp0_addr  out  5  CP0 register number.
- cp0_sel  out  3  CP0 select.
- cp0_writeData  out  32  write data.
- cp0_readData  in  32  CP0 read data, combinational from cp0_addr/cp0_sel in the same cycle.
- redirect_valid  out  1  one-cycle pulse.
- redirect_pc  out  32  fetch target, valid with redirect_valid.

## Operation
- Register numbers are fixed:
  - Status 12, Cause 13, EPC 14, BadVAddr 8, EBase 15, ErrorEPC 30.
  - cp0_sel = 1 for EBase; 0 otherwise.
- Accept:
  - Request inputs are latched at the accept edge.
  - If exc_valid and eret_valid are both high, the exception wins and the ERET is dropped.
  - Inputs are ignored outside IDLE.
- States: IDLE, E_STATUS, E_CAUSE, E_EPC, E_BADV, E_EBASE, R_STATUS, R_READ, REDIRECT.
- Exception path:
  - E_STATUS: read Status. Latch old EXL (bit 1) and BEV (bit 22). Write Status with bit 1 set, other bits unchanged.
  - E_CAUSE: write Cause = readData with [6:2] = exc_code. Bit 31 = exc_in_ds if old EXL=0; otherwise bit 31 is kept.
  - Next state after E_CAUSE: E_EPC if old EXL=0; else E_BADV if has_badvaddr; else E_EBASE.
  - E_EPC: write EPC = exc_pc − 4 (mod 2^32) if exc_in_ds, else exc_pc. Next state: E_BADV or E_EBASE.
  - E_BADV: write BadVAddr = exc_badvaddr.
  - E_EBASE: read EBase, no write. Register the vector:
    - BEV=1: 0xBFC00380.
    - BEV=0: {readData[31:12], 12'h180}.
    - Cause.IV is ignored.
- ERET path:
  - R_STATUS: read Status.
    - ERL (bit 2)=1: write Status with bit 2 cleared; target ErrorEPC.
    - ERL=0: write Status with bit 1 cleared; target EPC.
  - R_READ: read the target register, no write; register it as redirect_pc.
- REDIRECT: redirect_valid=1 for exactly one cycle, then IDLE.
- Write and port rules:
  - cp0_writeEn=1 only in E_STATUS, E_CAUSE, E_EPC, E_BADV, R_STATUS.
  - cp0_writeData is always 0 when writeEn=0.
  - cp0_addr/sel in IDLE/REDIRECT = 0.

## Timing
- Reset (rst low, asynchronous):
  - State is IDLE.
  - req_ready=1 while rst is high.
  - cp0_writeEn=0, cp0_addr=0, cp0_sel=0, cp0_writeData=0.
  - redirect_valid=0, redirect_pc=0.
  - All latched request fields are cleared.
- Reset mid-sequence aborts immediately. No further CP0 writes; writes already committed remain.
- All outputs are driven from state and registered values. CP0 writes take effect at the end of their state cycle.
- Exception latency, from accept edge to the redirect_valid cycle:
  - Full path: 6 cycles (STATUS, CAUSE, EPC, BADV, EBASE, REDIRECT).
  - Old EXL=1, no BadVAddr: 4 cycles.
  - Skipped states cost zero cycles.
- ERET latency: 3 cycles (R_STATUS, R_READ, REDIRECT).
- req_ready returns high in the cycle after REDIRECT. A new request accepted at that edge starts a new sequence with no bubble.

## Test plan
- Exception, Status=0x00400000 (BEV=1, EXL=0), exc_code=8, exc_pc=0x80001000, not in delay slot, no BadVAddr:
  - Writes Status=0x00400002, Cause[6:2]=8, Cause[31]=0, EPC=0x80001000.
  - redirect_pc=0xBFC00380 on cycle 5.
- Exception, BEV=0, EBase=0x80000000, exc_in_ds=1, exc_pc=0x80002004, has_badvaddr=1, badvaddr=0x00000003, exc_code=4:
  - EPC=0x80002000, Cause[31]=1, BadVAddr=0x00000003.
  - redirect_pc=0x80000180 on cycle 6.
- Nested exception with EXL=1 already set:
  - No EPC write; Cause[31] unchanged.
  - Redirect on cycle 4.
- ERET with Status=0x00000003, EPC=0x80003000:
  - Status written 0x00000001; redirect_pc=0x80003000 on cycle 3.
  - Repeat with ERL=1, ErrorEPC=0xBFC00000: clears bit 2; redirect_pc=0xBFC00000.
- Simultaneous exc_valid and eret_valid:
  - Exception sequence only; no ERET redirect follows.
- Reset asserted in E_CAUSE:
  - All outputs go 0 immediately; EPC is never written.
  - req_ready=1 after release.
